// File: rtl/int_entry_seq_pkg.sv
// ============================================================================
// Module : int_entry_seq_pkg
// Brief  : Shared types and constants for the interrupt entry sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package int_entry_seq_pkg;

  typedef enum logic [2:0] {
    INTSEQ_IDLE    = 3'd0,
    INTSEQ_VREQ    = 3'd1,
    INTSEQ_VWAIT   = 3'd2,
    INTSEQ_PUSH_SR = 3'd3,
    INTSEQ_PUSH_PC = 3'd4,
    INTSEQ_FETCH   = 3'd5,
    INTSEQ_DONE    = 3'd6
  } INTSEQ_state_t;

  localparam logic [31:0] INTSEQ_PUSH_SR_OFS = 32'd4;
  localparam logic [31:0] INTSEQ_PUSH_PC_OFS = 32'd8;

  // Vector table entry: VBR taken as-is, vector scaled to a longword offset.
  function automatic logic [31:0] intseq_vec_addr(input logic [31:0] vbr,
                                                  input logic [7:0]  vec);
    return vbr + {22'b0, vec, 2'b00};
  endfunction

endpackage

`default_nettype wire

// File: rtl/int_entry_seq.sv
// ============================================================================
// Module : int_entry_seq
// Brief  : Interrupt entry sequencer: vector handshake, SR/PC push, handler fetch.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module int_entry_seq
  import int_entry_seq_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        CE_R,
  input  logic        INT_REQ,
  input  logic [3:0]  INT_LVL,
  input  logic [7:0]  INT_VEC,
  output logic [3:0]  INT_MASK,
  output logic        INT_ACK,
  output logic        INT_ACP,
  output logic        VECT_REQ,
  input  logic        VECT_WAIT,
  input  logic        BOUNDARY,
  input  logic [31:0] SR,
  input  logic [31:0] PC,
  input  logic [31:0] R15,
  input  logic [31:0] VBR,
  output logic        STALL,
  output logic [31:0] MEM_A,
  output logic [31:0] MEM_DO,
  input  logic [31:0] MEM_DI,
  output logic        MEM_WE,
  output logic        MEM_REQ,
  input  logic        MEM_BUSY,
  output logic        LOAD,
  output logic [31:0] NEW_PC,
  output logic [31:0] NEW_R15,
  output logic [3:0]  NEW_SR_I
);

  INTSEQ_state_t state_q;
  logic [31:0]   sr_q, pc_q, r15_q, vbr_q;
  logic [7:0]    vec_q;
  logic [3:0]    lvl_q;
  logic          ack_q;
  logic [31:0]   new_pc_q, new_r15_q;
  logic          mem_done;

  assign INT_MASK = SR[7:4];
  assign INT_ACK  = ack_q;
  assign INT_ACP  = (state_q != INTSEQ_IDLE);
  assign STALL    = (state_q != INTSEQ_IDLE);
  assign VECT_REQ = (state_q == INTSEQ_VREQ);
  assign LOAD     = (state_q == INTSEQ_DONE);
  assign NEW_PC   = new_pc_q;
  assign NEW_R15  = new_r15_q;
  assign NEW_SR_I = lvl_q;

  // Bus port is decoded purely from registered state, so it stays stable
  // for the whole transfer however long MEM_BUSY holds it.
  always_comb begin
    MEM_REQ = 1'b0;
    MEM_WE  = 1'b0;
    MEM_A   = 32'h0;
    MEM_DO  = 32'h0;
    case (state_q)
      INTSEQ_PUSH_SR: begin
        MEM_REQ = 1'b1;
        MEM_WE  = 1'b1;
        MEM_A   = r15_q - INTSEQ_PUSH_SR_OFS;
        MEM_DO  = sr_q;
      end
      INTSEQ_PUSH_PC: begin
        MEM_REQ = 1'b1;
        MEM_WE  = 1'b1;
        MEM_A   = r15_q - INTSEQ_PUSH_PC_OFS;
        MEM_DO  = pc_q;
      end
      INTSEQ_FETCH: begin
        MEM_REQ = 1'b1;
        MEM_A   = intseq_vec_addr(vbr_q, vec_q);
      end
      default: ;
    endcase
  end

  assign mem_done = MEM_REQ && !MEM_BUSY;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= INTSEQ_IDLE;
      sr_q      <= 32'h0;
      pc_q      <= 32'h0;
      r15_q     <= 32'h0;
      vbr_q     <= 32'h0;
      vec_q     <= 8'h0;
      lvl_q     <= 4'h0;
      ack_q     <= 1'b0;
      new_pc_q  <= 32'h0;
      new_r15_q <= 32'h0;
    end else if (CE_R) begin
      ack_q <= 1'b0;
      case (state_q)
        INTSEQ_IDLE: begin
          if (INT_REQ && BOUNDARY) begin
            sr_q    <= SR;
            pc_q    <= PC;
            r15_q   <= R15;
            vbr_q   <= VBR;
            state_q <= INTSEQ_VREQ;
          end
        end
        INTSEQ_VREQ:  state_q <= INTSEQ_VWAIT;
        INTSEQ_VWAIT: begin
          if (!VECT_WAIT) begin
            vec_q   <= INT_VEC;
            lvl_q   <= INT_LVL;
            ack_q   <= 1'b1;
            state_q <= INTSEQ_PUSH_SR;
          end
        end
        INTSEQ_PUSH_SR: if (mem_done) state_q <= INTSEQ_PUSH_PC;
        INTSEQ_PUSH_PC: if (mem_done) state_q <= INTSEQ_FETCH;
        INTSEQ_FETCH: begin
          if (mem_done) begin
            new_pc_q  <= MEM_DI;
            new_r15_q <= r15_q - INTSEQ_PUSH_PC_OFS;
            state_q   <= INTSEQ_DONE;
          end
        end
        INTSEQ_DONE: state_q <= INTSEQ_IDLE;
        default:     state_q <= INTSEQ_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
